// File: rtl/crypto_veril.sv
// crypto_veril: three-stage pipelined 16-bit scrambler with a 5-bit key.
// Latency: 3 clocks from the first start cycle after a load to output_data.
// Backpressure: dropping start freezes every stage in place; ld flushes in-flight work.
//
// Ports:
//    clk1        - sole clock, rising edge
//    rst         - synchronous active-high reset, clears every register
//    input_data  - 16-bit plaintext operand, captured on ld
//    key_bits    - 5-bit key operand, captured on ld
//    ld          - load strobe: captures operands, clears the done flags
//    start       - run enable: all stages advance while high (and ld low)
//    output_data - registered stage-3 result, held until a new result lands
module crypto_veril (
   input  logic        clk1,
   input  logic        rst,
   input  logic [15:0] input_data,
   input  logic [4:0]  key_bits,
   input  logic        ld,
   input  logic        start,
   output logic [15:0] output_data
);

   // Operand registers
   logic [15:0] data_reg;
   logic [4:0]  key_reg;

   // Pipeline stage registers and valid flags
   logic [15:0] stg1_out;
   logic [16:0] stg2_out;
   logic [15:0] stg3_out;
   logic        stg1_done;
   logic        stg2_done;

   // Combinational next values for each stage
   logic [15:0] k16;
   logic [15:0] stg1_nxt;
   logic [16:0] stg2_nxt;
   logic [15:0] stg3_fold;
   logic [15:0] stg3_nxt;

   // 16-bit rotate left by 0..15: shift a doubled copy and keep the top half.
   function automatic logic [15:0] rotl16(input logic [15:0] d, input logic [3:0] s);
      logic [31:0] dd;
      dd = {d, d} << s;
      return dd[31:16];
   endfunction

   always_comb begin
      k16       = {key_reg, key_reg, key_reg, key_reg[4]};
      stg1_nxt  = rotl16(data_reg, key_reg[3:0]) ^ k16;
      stg2_nxt  = {1'b0, stg1_out} + {1'b0, ~k16};
      // Carry-out from stage 2 inverts every result bit.
      stg3_fold = stg2_out[15:0] ^ {16{stg2_out[16]}};
      stg3_nxt  = key_reg[4] ? {stg3_fold[7:0], stg3_fold[15:8]} : stg3_fold;
   end

   // Priority: rst, then ld, then start. Stage 2 may consume a stale stage-1
   // value on the first run edge, but its done flag stays low, so stage 3
   // never latches it.
   always_ff @(posedge clk1) begin
      if (rst) begin
         data_reg    <= '0;
         key_reg     <= '0;
         stg1_out    <= '0;
         stg2_out    <= '0;
         stg3_out    <= '0;
         stg1_done   <= 1'b0;
         stg2_done   <= 1'b0;
         output_data <= '0;
      end else if (ld) begin
         data_reg  <= input_data;
         key_reg   <= key_bits;
         stg1_done <= 1'b0;
         stg2_done <= 1'b0;
      end else if (start) begin
         stg1_out  <= stg1_nxt;
         stg1_done <= 1'b1;
         stg2_out  <= stg2_nxt;
         stg2_done <= stg1_done;
         if (stg2_done) begin
            stg3_out    <= stg3_nxt;
            output_data <= stg3_nxt;
         end
      end
   end

endmodule

// File: tb/tb_crypto_veril.sv
module tb_crypto_veril;

   logic        clk1;
   logic        rst;
   logic [15:0] input_data;
   logic [4:0]  key_bits;
   logic        ld;
   logic        start;
   logic [15:0] output_data;

   int n_checks;
   int n_errors;

   crypto_veril dut (
      .clk1        (clk1),
      .rst         (rst),
      .input_data  (input_data),
      .key_bits    (key_bits),
      .ld          (ld),
      .start       (start),
      .output_data (output_data)
   );

   initial clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   task automatic check_val(input string tag, input logic [16:0] got, input logic [16:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk1);
         #1;
      end
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      rst        = 1'b1;
      start      = 1'b1;
      ld         = 1'b0;
      input_data = 16'hBEEF;
      key_bits   = 5'h1F;

      // Reset held with start high
      step(3);
      check_val("rst_out",   output_data,      17'h0);
      check_val("rst_s1",    dut.stg1_out,     17'h0);
      check_val("rst_s2",    dut.stg2_out,     17'h0);
      check_val("rst_s3",    dut.stg3_out,     17'h0);
      check_val("rst_d1",    dut.stg1_done,    17'h0);
      check_val("rst_d2",    dut.stg2_done,    17'h0);

      // Nominal: 0x00FF, key 11001
      rst = 1'b0; start = 1'b0;
      input_data = 16'h00FF; key_bits = 5'b11001; ld = 1'b1;
      step(1);
      check_val("nom_ld_d1", dut.stg1_done, 17'h0);
      ld = 1'b0; start = 1'b1;
      step(1);
      check_val("nom_s1",    dut.stg1_out,  17'h3072);
      check_val("nom_e_d1",  dut.stg1_done, 17'h1);
      check_val("nom_e_d2",  dut.stg2_done, 17'h0);
      check_val("nom_e_out", output_data,   17'h0);
      step(1);
      check_val("nom_s2",    dut.stg2_out,  17'h061FE);
      check_val("nom_e1_d2", dut.stg2_done, 17'h1);
      check_val("nom_e1_out", output_data,  17'h0);
      step(1);
      check_val("nom_out",   output_data,   17'hFE61);
      check_val("nom_s3",    dut.stg3_out,  17'hFE61);
      step(3);
      check_val("nom_hold",  output_data,   17'hFE61);

      // Carry path: 0xFFFF, key 0
      start = 1'b0; input_data = 16'hFFFF; key_bits = 5'b00000; ld = 1'b1;
      step(1);
      check_val("cry_ld_out", output_data,  17'hFE61);
      ld = 1'b0; start = 1'b1;
      step(2);
      check_val("cry_mid_out", output_data, 17'hFE61);
      step(1);
      check_val("cry_s1",    dut.stg1_out,  17'hFFFF);
      check_val("cry_s2",    dut.stg2_out,  17'h1FFFE);
      check_val("cry_out",   output_data,   17'h0001);

      // Stall: 0x1234, key 00011 -> s1 8966, s2 1709F, out 8F60
      start = 1'b0; input_data = 16'h1234; key_bits = 5'b00011; ld = 1'b1;
      step(1);
      ld = 1'b0; start = 1'b1;
      step(1);
      start = 1'b0;
      step(4);
      check_val("stl_s1",    dut.stg1_out,  17'h8966);
      check_val("stl_d1",    dut.stg1_done, 17'h1);
      check_val("stl_d2",    dut.stg2_done, 17'h0);
      check_val("stl_out",   output_data,   17'h0001);
      start = 1'b1;
      step(1);
      check_val("stl_s2",    dut.stg2_out,  17'h1709F);
      check_val("stl_r1_out", output_data,  17'h0001);
      step(1);
      check_val("stl_out2",  output_data,   17'h8F60);

      // Reload mid-flight, also ld and start high together
      start = 1'b0; input_data = 16'h00FF; key_bits = 5'b11001; ld = 1'b1;
      step(1);
      ld = 1'b0; start = 1'b1;
      step(1);
      check_val("rl_e_s1",   dut.stg1_out,  17'h3072);
      input_data = 16'hA5C3; key_bits = 5'b10000; ld = 1'b1;
      step(1);
      check_val("rl_d1",     dut.stg1_done, 17'h0);
      check_val("rl_d2",     dut.stg2_done, 17'h0);
      check_val("rl_out",    output_data,   17'h8F60);
      check_val("rl_s1_hold", dut.stg1_out, 17'h3072);
      ld = 1'b0;
      step(2);
      check_val("rl_mid_out", output_data,  17'h8F60);
      step(1);
      check_val("rl_s1",     dut.stg1_out,  17'h21E2);
      check_val("rl_s2",     dut.stg2_out,  17'h09DC0);
      check_val("rl_out2",   output_data,   17'hC09D);

      // Multi-cycle ld: last operands win
      start = 1'b0; input_data = 16'hFFFF; key_bits = 5'b00000; ld = 1'b1;
      step(1);
      input_data = 16'h00FF; key_bits = 5'b11001;
      step(1);
      ld = 1'b0; start = 1'b1;
      step(3);
      check_val("mld_out",   output_data,   17'hFE61);

      // Reset mid-operation zeroes everything on that edge
      rst = 1'b1;
      step(1);
      check_val("mrst_out",  output_data,   17'h0);
      check_val("mrst_s2",   dut.stg2_out,  17'h0);
      check_val("mrst_d1",   dut.stg1_done, 17'h0);
      check_val("mrst_key",  dut.key_reg,   17'h0);
      rst = 1'b0; start = 1'b0;
      step(1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
